// File: rtl/fme_pkg.sv
// Shared definitions for the fractional-motion-estimation window feeder.
package fme_pkg;

    localparam int PIXELS_PER_ROW = 32;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        DRENA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    // Number of memory words needed to assemble one full pixel row.
    function automatic int calc_wpr(input int data_width, input int mem_width);
        return (PIXELS_PER_ROW * data_width) / mem_width;
    endfunction

endpackage

// File: rtl/fme_fifo_linhas.sv
// Two-entry row FIFO between the row assembler and the downstream consumer.
module fme_fifo_linhas #(
    parameter int WIDTH = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop; a push into a full FIFO is accepted when a pop frees the slot.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 2'd1;
        end else if (do_pop && !do_push) begin
            count_next = count - 2'd1;
        end
    end

    // Storage, pointers and registered full/empty flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
            empty <= (count_next == 2'd0);
            full  <= (count_next == 2'd2);
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fme_carrega_janela.sv
// Reference-window fetcher: reads rows word by word, assembles them and streams
// completed rows out through a two-row buffer.
module fme_carrega_janela
    import fme_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ROWS       = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [ADDR_WIDTH-1:0]                stride,
    output logic                                 mem_rd,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic [MEM_WIDTH-1:0]                 mem_data,
    output logic [PIXELS_PER_ROW*DATA_WIDTH-1:0] row_out,
    output logic                                 row_valid,
    input  logic                                 row_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ROW_WIDTH = PIXELS_PER_ROW * DATA_WIDTH;
    localparam int WPR       = calc_wpr(DATA_WIDTH, MEM_WIDTH);
    localparam int W_W       = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int R_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [W_W-1:0] LAST_WORD = W_W'(WPR - 1);
    localparam logic [R_W-1:0] LAST_ROW  = R_W'(ROWS - 1);

    estado_t               state;
    estado_t               next_state;

    logic [ADDR_WIDTH-1:0] row_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [W_W-1:0]        word_cnt;
    logic [R_W-1:0]        row_cnt;
    logic [ADDR_WIDTH-1:0] cur_row_addr;
    logic [ADDR_WIDTH-1:0] cur_stride;
    logic [W_W-1:0]        cur_word;
    logic [R_W-1:0]        cur_row;
    logic [1:0]            rows_held;
    logic                  issue;
    logic                  slot_free;
    logic                  fetch_last;
    logic                  pop;

    logic                  rd_q;
    logic [W_W-1:0]        asm_word;
    logic                  push_pend;
    logic [ROW_WIDTH-1:0]  asm_row;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;

    // Fetch pointers: while idle the start inputs act directly as row 0, word 0,
    // so the first read goes out on the same edge that accepts start.
    always_comb begin
        pop       = !fifo_empty && row_ready;
        slot_free = (rows_held < 2'd2) || pop;
        if (state == OCIOSO) begin
            cur_row_addr = base_addr;
            cur_stride   = stride;
            cur_word     = '0;
            cur_row      = '0;
        end else begin
            cur_row_addr = row_addr;
            cur_stride   = stride_q;
            cur_word     = word_cnt;
            cur_row      = row_cnt;
        end
        issue = 1'b0;
        if (state == OCIOSO) begin
            issue = start;
        end else if (state == BUSCA) begin
            issue = (cur_word != '0) || slot_free;
        end
        fetch_last = issue && (cur_word == LAST_WORD) && (cur_row == LAST_ROW);
    end

    // Next-state logic: drain finishes on the handshake of the last held row.
    always_comb begin
        next_state = state;
        case (state)
            OCIOSO: if (start) next_state = fetch_last ? DRENA : BUSCA;
            BUSCA:  if (fetch_last) next_state = DRENA;
            DRENA:  if ((rows_held == 2'd0) || ((rows_held == 2'd1) && pop)) next_state = FIM;
            FIM:    next_state = OCIOSO;
            default: next_state = OCIOSO;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= OCIOSO;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != OCIOSO);
            done  <= (next_state == FIM);
        end
    end

    // Read issue, address/row/word counters and count of rows reserved in the buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            row_addr  <= '0;
            stride_q  <= '0;
            word_cnt  <= '0;
            row_cnt   <= '0;
            rows_held <= 2'd0;
        end else begin
            mem_rd <= issue;
            if (issue) begin
                mem_addr <= cur_row_addr + ADDR_WIDTH'(cur_word);
                if (cur_word == LAST_WORD) begin
                    word_cnt <= '0;
                    row_cnt  <= cur_row + R_W'(1);
                    row_addr <= cur_row_addr + cur_stride;
                end else begin
                    word_cnt <= cur_word + W_W'(1);
                    row_cnt  <= cur_row;
                    row_addr <= cur_row_addr;
                end
            end
            if ((state == OCIOSO) && start) begin
                stride_q <= stride;
            end
            case ({issue && (cur_word == '0), pop})
                2'b10:   rows_held <= rows_held + 2'd1;
                2'b01:   rows_held <= rows_held - 2'd1;
                default: rows_held <= rows_held;
            endcase
        end
    end

    // Row assembly: capture each word the cycle after its read, flag the row for push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q      <= 1'b0;
            asm_word  <= '0;
            push_pend <= 1'b0;
            asm_row   <= '0;
        end else begin
            rd_q      <= mem_rd;
            push_pend <= rd_q && (asm_word == LAST_WORD);
            if (rd_q) begin
                asm_row[int'(asm_word)*MEM_WIDTH +: MEM_WIDTH] <= mem_data;
                asm_word <= (asm_word == LAST_WORD) ? '0 : asm_word + W_W'(1);
            end
        end
    end

    assign fifo_push = push_pend && (!fifo_full || pop);

    fme_fifo_linhas #(
        .WIDTH (ROW_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (asm_row),
        .pop       (pop),
        .pop_data  (row_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign row_valid = !fifo_empty;

endmodule

// File: tb/tb_fme_carrega_janela.sv
// Self-checking bench for fme_carrega_janela against a window-level reference model.
module tb_fme_carrega_janela;

    localparam int DW   = 8;
    localparam int MW   = 64;
    localparam int AW   = 16;
    localparam int ROWS = 16;
    localparam int WPR  = 4;
    localparam int RW   = 32 * DW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_data = '0;
    logic [RW-1:0] row_out;
    logic          row_valid;
    logic          row_ready = 1'b0;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ready_mode = 0;
    int            mem_mode = 0;
    bit            monitor_on = 1'b0;
    logic [AW-1:0] addr_q [$];
    logic [RW-1:0] row_q [$];
    int            rd_count;
    int            rows_got;
    int            done_count;
    int            first_valid_cyc;
    bit            first_seen;
    bit            prev_hold;
    logic [RW-1:0] prev_row;
    int            t0;

    fme_carrega_janela #(
        .DATA_WIDTH (DW),
        .MEM_WIDTH  (MW),
        .ADDR_WIDTH (AW),
        .ROWS       (ROWS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .row_out   (row_out),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [RW-1:0] observed,
                               input logic [RW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference-frame contents: mode 0 is the simple replicated-byte pattern,
    // mode 1 encodes the full address so wrapped addresses are distinguishable.
    function automatic logic [MW-1:0] memWord(input logic [AW-1:0] a, input int mode);
        logic [15:0] m;
        m = a * 16'd7;
        if (mode == 0) return {8{a[7:0]}};
        return {a ^ 16'hA5A5, m, ~a, a};
    endfunction

    // Cycle counter, advanced on every rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous memory with one cycle of read latency; garbage when not read.
    always @(posedge clock) begin
        if (mem_rd) mem_data <= memWord(mem_addr, mem_mode);
        else        mem_data <= {$urandom, $urandom};
    end

    // Consumer ready: always high, random 50%, or held low.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       row_ready = 1'b1;
                1:       row_ready = 1'($urandom_range(0, 1));
                default: row_ready = 1'b0;
            endcase
        end
    end

    // Monitor: read addresses, delivered rows, stability under backpressure, done pulses.
    always @(negedge clock) begin
        if (monitor_on && reset) begin
            if (mem_rd) begin
                rd_count++;
                if (addr_q.size() == 0) checkOutput("extraRead", 1, 0);
                else checkOutput("memAddr", mem_addr, addr_q.pop_front());
            end
            if (prev_hold) begin
                checkOutput("holdValid", row_valid, 1);
                checkOutput("holdRow", row_out, prev_row);
            end
            if (row_valid && !first_seen) begin
                first_seen      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (row_valid && row_ready) begin
                rows_got++;
                if (row_q.size() == 0) checkOutput("extraRow", 1, 0);
                else checkOutput("rowData", row_out, row_q.pop_front());
            end
            if (done) done_count++;
            prev_hold = row_valid && !row_ready;
            prev_row  = row_out;
        end
    end

    // Build the expected window and pulse start; t0 is the cycle count at the start edge.
    task automatic startWindow(input logic [AW-1:0] b, input logic [AW-1:0] s);
        logic [AW-1:0] ad;
        logic [RW-1:0] row;
        addr_q.delete();
        row_q.delete();
        rd_count        = 0;
        rows_got        = 0;
        done_count      = 0;
        first_seen      = 1'b0;
        first_valid_cyc = -1;
        prev_hold       = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            row = '0;
            for (int w = 0; w < WPR; w++) begin
                ad = b + AW'(r) * s + AW'(w);
                addr_q.push_back(ad);
                row[w*MW +: MW] = memWord(ad, mem_mode);
            end
            row_q.push_back(row);
        end
        @(negedge clock);
        base_addr  = b;
        stride     = s;
        start      = 1'b1;
        monitor_on = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t0    = cyc;
    endtask

    // Run one full window with optional backpressure, ignored restart and timing checks.
    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] s, input int r_mode,
                                 input int bp, input bit ghost, input bit timing);
        bit ok;
        ready_mode = (bp > 0) ? 2 : r_mode;
        startWindow(b, s);
        if (bp > 0) begin
            for (int i = 0; i < 50; i++) begin
                @(negedge clock);
                if (row_valid) break;
            end
            repeat (bp) @(negedge clock);
            checkOutput("bpReads", rd_count, 2 * WPR);
            checkOutput("bpStall", mem_rd, 0);
            checkOutput("bpValid", row_valid, 1);
            ready_mode = r_mode;
        end
        if (ghost) begin
            repeat (20) @(negedge clock);
            base_addr = b ^ 16'h1234;
            start     = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("doneSeen", ok, 1);
        if (ok) begin
            if (timing) begin
                checkOutput("firstValid", first_valid_cyc - t0, 6);
                checkOutput("doneTime", cyc - t0, ROWS * WPR + 3);
            end
            checkOutput("busyAtDone", busy, 1);
        end
        @(negedge clock);
        checkOutput("busyAfter", busy, 0);
        checkOutput("doneOnce", done_count, 1);
        checkOutput("rowsGot", rows_got, ROWS);
        checkOutput("rowQEmpty", row_q.size(), 0);
        checkOutput("addrQEmpty", addr_q.size(), 0);
        monitor_on = 1'b0;
    endtask

    // Watchdog against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] rb;
        logic [AW-1:0] rs;

        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rstMemRd", mem_rd, 0);
        checkOutput("rstValid", row_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRow", row_out, 0);
        reset = 1'b1;

        $display("[TB] basic window");
        mem_mode = 0;
        applyStimulus(16'h0100, 16'd8, 0, 0, 1'b0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(16'h0100, 16'd8, 0, 20, 1'b0, 1'b0);

        $display("[TB] wrap with zero stride");
        mem_mode = 1;
        applyStimulus(16'hFFFE, 16'd0, 0, 0, 1'b0, 1'b1);

        $display("[TB] start while busy");
        applyStimulus(16'h2000, 16'd24, 0, 0, 1'b1, 1'b1);

        $display("[TB] reset mid-window");
        ready_mode = 1;
        startWindow(16'h3000, 16'd40);
        repeat (25) @(negedge clock);
        #2;
        reset      = 1'b0;
        monitor_on = 1'b0;
        #1;
        checkOutput("midRstMemRd", mem_rd, 0);
        checkOutput("midRstAddr", mem_addr, 0);
        checkOutput("midRstRow", row_out, 0);
        checkOutput("midRstValid", row_valid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("heldRstValid", row_valid, 0);
        checkOutput("heldRstBusy", busy, 0);
        reset = 1'b1;
        applyStimulus(16'h0C00, 16'd5, 1, 0, 1'b0, 1'b0);

        $display("[TB] random windows");
        for (int n = 0; n < 10; n++) begin
            rb = AW'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            applyStimulus(rb, rs, 1, 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fme_carrega_janela.md
# fme_carrega_janela

Upstream feeder for the fractional-motion-estimation interpolator. On a start pulse it fetches a rectangular reference window from a synchronous, word-wide reference-frame memory. It assembles each 32-pixel row from several memory words and streams the completed rows downstream over a valid/ready handshake. A two-row buffer decouples memory fetch from consumption, so row fetch overlaps row delivery.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per pixel
- MEM_WIDTH, 64, memory word width; must be a multiple of DATA_WIDTH
- ADDR_WIDTH, 16, memory word-address width
- ROWS, 16, rows per window

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- base_addr  in  ADDR_WIDTH  word address of window row 0, word 0; sampled with start
- stride  in  ADDR_WIDTH  word distance between consecutive rows; sampled with start
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_data  in  MEM_WIDTH  read data, valid exactly 1 cycle after mem_rd
- row_out  out  32*DATA_WIDTH  pixel k at bits [DATA_WIDTH*k +: DATA_WIDTH]
- row_valid  out  1  row_out holds a complete row
- row_ready  in  1  consumer accepts row when row_valid && row_ready
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last row handshake

## Operation
- WPR = 32*DATA_WIDTH/MEM_WIDTH words per row (default 4). Word w of row r is read at base_addr + r*stride + w.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently. stride = 0 is legal and repeats row 0.
- Word w maps to pixels [w*MEM_WIDTH/DATA_WIDTH ..], so memory word 0 holds the lowest pixels.
- FSM states:
  - OCIOSO: idle. start → BUSCA, latching base_addr and stride and clearing counters.
  - BUSCA: issues one read per cycle for WPR cycles, but only while a buffer slot is free or will be freed by the in-flight row. After the last word of row ROWS-1 → DRENA. If no slot is free, the FSM stalls in BUSCA with mem_rd=0.
  - DRENA: waits until the buffer is empty and the last handshake has occurred → FIM.
  - FIM: done=1 for one cycle → OCIOSO.
- The assembly register captures mem_data on the cycle after each mem_rd. A completed row is pushed into the 2-entry row FIFO; row_valid = FIFO not empty.
- row_out and row_valid are stable while row_valid && !row_ready.
- A push and a pop in the same cycle on a full FIFO are both legal; the occupancy is unchanged.
- start while busy is ignored; no state change.
- Reset (asynchronous, any time, including mid-window) forces:
  - state OCIOSO; all counters and the FIFO cleared
  - mem_rd=0, mem_addr=0, row_out=0, row_valid=0, busy=0, done=0
- Data already in flight from the memory is discarded.

## Timing
- All outputs are registered.
- Start sampled at edge T0:
  - mem_rd high in cycles T0+1..T0+WPR
  - words captured at edges T0+2..T0+WPR+1
  - row_valid rises after edge T0+WPR+2, i.e. T0+6 with the defaults
- With row_ready held high, throughput is one row per WPR cycles and reads are back-to-back across row boundaries.
- With row_ready held low, reads stop after 2 rows buffered plus at most 0 extra rows in assembly. Fetch resumes the cycle after a pop frees a slot.
- busy rises after T0 and falls together with the done pulse ending.
- The done pulse occurs the cycle after the final handshake.
- Minimum start-to-done time with ready high is ROWS*WPR + 3 cycles.

## Structure
- Shared package fme_pkg:
  - PIXELS_PER_ROW = 32
  - FSM state encoding (OCIOSO, BUSCA, DRENA, FIM)
  - WPR derivation function
- One sub-module, fme_fifo_linhas: 2-entry, 32*DATA_WIDTH-wide FIFO with push/pop/full/empty, asynchronous active-low reset.
- The top of this block holds the FSM, the address/row/word counters and the assembly register.

## Test plan
- Reset: hold reset low 3 cycles mid-transfer → all outputs 0 immediately; a new start afterwards fetches from the new base_addr.
- Basic window: base_addr=0x0100, stride=8, memory word at address a = {8{a[7:0]}}, ready=1.
  - 16 rows arrive with correct pixel packing.
  - First row_valid at T0+6; done at T0+67.
- Backpressure: ready=0 for 20 cycles after the first row_valid → mem_rd deasserts after the second row is assembled, row_out stays stable, no data lost after ready returns.
- Wrap and zero stride: base_addr=0xFFFE, stride=0 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 repeated for every row; all rows identical.
- Start while busy: pulse start with different base_addr mid-window → ignored; output identical to an undisturbed run.
- Random ready toggling (50%) over 10 windows → row order and content match the reference model; exactly one done per start.
